freq_select_divider: RTL

FREQ_SELECT_DIVIDER -- requirements
Module: freq_select_divider

---
 rtl/freq_select_divider.sv | 121 ++++++++++++
 1 files changed

// File: rtl/freq_select_divider.sv
// Button-selected clock-enable divider: two debounced buttons step through NUM_MODES
// rates, divisor BASE_DIV << (mode*DIV_SHIFT). Define FREQSEL_PAUSE_EN to add a pause input.
module freq_select_divider #(
  parameter int NUM_MODES       = 4,
  parameter int INIT_MODE       = 0,
  parameter int BASE_DIV        = 4,
  parameter int DIV_SHIFT       = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int MODE_W         = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_next,
  input  logic              btn_prev,
`ifdef FREQSEL_PAUSE_EN
  input  logic              pause,
`endif
  output logic [MODE_W-1:0] mode,
  output logic              tick,
  output logic              mode_chg
);

  localparam longint unsigned MAX_DIV = 64'(BASE_DIV) << ((NUM_MODES - 1) * DIV_SHIFT);
  localparam int CNT_W = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

  // Button index 0 is "next", index 1 is "prev".
  logic [1:0]      btn_raw;
  logic [1:0]      sync_1;
  logic [1:0]      sync_2;
  logic [1:0]      db_lvl;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  assign btn_raw = {btn_prev, btn_next};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
      db_lvl <= '0;
      press  <= '0;
      // NOTE: the debounce counter array is small state, so it is reset like any other flop.
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      press  <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync_2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          db_lvl[i] <= sync_2[i];
          press[i]  <= sync_2[i];  // rising edge of the debounced level only
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic              next_ev;
  logic              prev_ev;
  logic              mode_upd;
  logic [MODE_W-1:0] mode_nxt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_ev  = press[0] & ~press[1];
    prev_ev  = press[1] & ~press[0];
    mode_upd = next_ev | prev_ev;
    mode_nxt = mode;
    if (next_ev) begin
      mode_nxt = (mode == MODE_LAST) ? '0 : mode + MODE_W'(1);
    end else if (prev_ev) begin
      mode_nxt = (mode == '0) ? MODE_LAST : mode - MODE_W'(1);
    end
  end

  // Terminal count per mode, folded to constants at elaboration.
  logic [CNT_W-1:0] term_tbl [NUM_MODES];
  for (genvar g = 0; g < NUM_MODES; g++) begin : g_term
    assign term_tbl[g] = CNT_W'((64'(BASE_DIV) << (g * DIV_SHIFT)) - 64'd1);
  end

  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_term;
  logic             hold;
  logic             at_term;

`ifdef FREQSEL_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign div_term = term_tbl[mode];
  assign at_term  = (div_cnt == div_term);
  assign tick     = at_term & ~mode_upd & ~hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= MODE_W'(INIT_MODE);
      mode_chg <= 1'b0;
      div_cnt  <= '0;
    end else begin
      mode     <= mode_nxt;
      mode_chg <= mode_upd;
      if (mode_upd) begin
        div_cnt <= '0;  // restart so the new rate gets a full first period
      end else if (!hold) begin
        div_cnt <= at_term ? '0 : div_cnt + CNT_W'(1);
      end
    end
  end

endmodule
